// File: rtl/cnt8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cnt8_arbiter
//  Description : Round-robin arbiter that shares an octal counter (counter8)
//                between two requesters. It sequences the counter's load/inc
//                controls for the granted command (one load, or a burst of N
//                increments) and reports counter wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt8_arbiter #(
    parameter int LEN_W    = 3,
    parameter bit PRI_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic             cmd0,
    input  logic             cmd1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [2:0]       state,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             load,
    output logic             inc,
    output logic             busy,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam int          REM_W     = LEN_W + 1;
    localparam logic [REM_W-1:0] c_REM_ONE = REM_W'(1);
    localparam logic [REM_W-1:0] c_REM_MAX = {1'b1, {LEN_W{1'b0}}};

    fsm_t             fsm_q,  fsm_d;
    logic             win_q,  win_d;    // granted requester index
    logic             cmd_q,  cmd_d;    // latched command: 1 = load
    logic [REM_W-1:0] rem_q,  rem_d;    // increments still to issue
    logic             ptr_q,  ptr_d;    // round-robin priority owner
    logic [1:0]       gnt_q,  gnt_d;
    logic [1:0]       done_q, done_d;
    logic             load_q, load_d;
    logic             inc_q,  inc_d;
    logic             wrap_q;

    // Winner selection and command/length capture for the IDLE edge
    logic             w_win;
    logic             w_cmd;
    logic [LEN_W-1:0] w_len;
    logic [REM_W-1:0] w_rem_init;
    logic [1:0]       w_win_oh;
    logic [1:0]       w_cur_oh;

    assign w_win      = (req == 2'b11) ? ptr_q : req[1];
    assign w_cmd      = w_win ? cmd1 : cmd0;
    assign w_len      = w_win ? len1 : len0;
    // A zero length encodes the maximum burst of 2^LEN_W increments
    assign w_rem_init = (w_len == '0) ? c_REM_MAX : {1'b0, w_len};
    assign w_win_oh   = w_win ? 2'b10 : 2'b01;
    assign w_cur_oh   = win_q ? 2'b10 : 2'b01;

    // Next-state and next-output computation; outputs are registered below
    always_comb begin
        fsm_d  = fsm_q;
        win_d  = win_q;
        cmd_d  = cmd_q;
        rem_d  = rem_q;
        ptr_d  = ptr_q;
        gnt_d  = 2'b00;
        done_d = 2'b00;
        load_d = 1'b0;
        inc_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    win_d  = w_win;
                    cmd_d  = w_cmd;
                    rem_d  = w_rem_init;
                    gnt_d  = w_win_oh;
                    load_d = w_cmd;
                    inc_d  = ~w_cmd;
                    fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (!req[win_q]) begin
                    // Abort: drop everything, no done pulse, priority still rotates
                    fsm_d = S_IDLE;
                    ptr_d = ~win_q;
                end else if (cmd_q) begin
                    fsm_d  = S_DONE;
                    done_d = w_cur_oh;
                end else begin
                    rem_d = rem_q - c_REM_ONE;
                    if (rem_q == c_REM_ONE) begin
                        fsm_d  = S_DONE;
                        done_d = w_cur_oh;
                    end else begin
                        gnt_d = w_cur_oh;
                        inc_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
                ptr_d = ~win_q;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops all controls at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= S_IDLE;
            win_q  <= 1'b0;
            cmd_q  <= 1'b0;
            rem_q  <= '0;
            ptr_q  <= PRI_INIT;
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            load_q <= 1'b0;
            inc_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            win_q  <= win_d;
            cmd_q  <= cmd_d;
            rem_q  <= rem_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            done_q <= done_d;
            load_q <= load_d;
            inc_q  <= inc_d;
        end
    end

    // Wrap pulse: the counter just took an increment while sitting at 7
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= inc_q & (state == 3'o7);
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign load = load_q;
    assign inc  = inc_q;
    assign busy = (fsm_q != S_IDLE);
    assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt8_arbiter
//  Description : Directed self-checking bench for cnt8_arbiter, with a small
//                behavioural counter8 closing the load/inc -> state loop.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cnt8_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic       cmd0, cmd1;
    logic [2:0] len0, len1;
    logic [2:0] cnt = 3'o0;
    logic [1:0] gnt, done;
    logic       load, inc, busy, wrap;

    int n_checks = 0;
    int n_errors = 0;

    cnt8_arbiter #(.LEN_W(3), .PRI_INIT(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .cmd0    (cmd0),
        .cmd1    (cmd1),
        .len0    (len0),
        .len1    (len1),
        .state   (cnt),
        .gnt     (gnt),
        .done    (done),
        .load    (load),
        .inc     (inc),
        .busy    (busy),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    // Behavioural counter8: load clears, inc counts modulo 8
    always @(posedge clk) begin
        if (load)     cnt <= 3'o0;
        else if (inc) cnt <= cnt + 3'o1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester r issues an inc burst; expectations derived from start state
    task automatic run_burst(input int r, input int len, input int start, input int exp_wraps);
        int n;
        int wraps;
        logic [1:0] oh;
        n     = (len == 0) ? 8 : len;
        wraps = 0;
        oh    = (r == 1) ? 2'b10 : 2'b01;
        if (r == 1) begin cmd1 = 1'b0; len1 = 3'(len); end
        else        begin cmd0 = 1'b0; len0 = 3'(len); end
        req = oh;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check_eq("burst_gnt", 32'(gnt), 32'(oh));
            check_eq("burst_inc", 32'(inc), 32'd1);
            check_eq("burst_state", 32'(cnt), 32'((start + k - 1) % 8));
            check_eq("burst_wrap", 32'(wrap), 32'((k >= 2 && ((start + k - 2) % 8) == 7) ? 1 : 0));
            wraps += int'(wrap);
        end
        @(negedge clk);
        check_eq("burst_done", 32'(done), 32'(oh));
        check_eq("burst_done_inc", 32'(inc), 32'd0);
        check_eq("burst_end_state", 32'(cnt), 32'((start + n) % 8));
        wraps += int'(wrap);
        req = 2'b00;
        @(negedge clk);
        check_eq("burst_idle_busy", 32'(busy), 32'd0);
        wraps += int'(wrap);
        check_eq("burst_wrap_count", 32'(wraps), 32'(exp_wraps));
    endtask

    // Requester r issues a single load
    task automatic run_load(input int r);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        if (r == 1) cmd1 = 1'b1; else cmd0 = 1'b1;
        req = oh;
        @(negedge clk);
        check_eq("load_gnt", 32'(gnt), 32'(oh));
        check_eq("load_pulse", 32'(load), 32'd1);
        check_eq("load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("load_done", 32'(done), 32'(oh));
        check_eq("load_drop", 32'(load), 32'd0);
        check_eq("load_state", 32'(cnt), 32'd0);
        req = 2'b00;
        @(negedge clk);
        check_eq("load_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_g [4];
        reset_n = 1'b0;
        req = 2'b00; cmd0 = 1'b0; cmd1 = 1'b0; len0 = 3'd0; len1 = 3'd0;
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ctl", 32'({load, inc, busy, wrap}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Contention with both requesters loading: 01,10,01,10
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        cmd0 = 1'b1; cmd1 = 1'b1; req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rr_gnt", 32'(gnt), 32'(exp_g[i]));
            check_eq("rr_load", 32'(load), 32'd1);
            @(negedge clk);
            check_eq("rr_done", 32'(done), 32'(exp_g[i]));
            check_eq("rr_gap_gnt", 32'(gnt), 32'd0);
            if (i == 3) req = 2'b00;
            @(negedge clk);
            check_eq("rr_idle", 32'(busy), 32'd0);
        end

        run_load(0);                 // state 0, priority to 1
        run_burst(1, 3, 0, 0);       // 0 -> 3
        run_burst(1, 0, 3, 1);       // 8 incs: 3 -> 3, one wrap
        run_burst(0, 3, 3, 0);       // 3 -> 6
        run_burst(1, 3, 6, 1);       // 6,7,0,1 with one wrap

        // Abort in the second cycle of a 5-increment burst
        cmd0 = 1'b0; len0 = 3'd5; req = 2'b01;
        @(negedge clk);
        check_eq("abort_inc1", 32'(inc), 32'd1);
        @(negedge clk);
        check_eq("abort_inc2", 32'(inc), 32'd1);
        req = 2'b00;
        @(negedge clk);
        check_eq("abort_ctl", 32'({gnt, inc, load, busy}), 32'd0);
        check_eq("abort_no_done", 32'(done), 32'd0);
        check_eq("abort_state", 32'(cnt), 32'd3);
        @(negedge clk);
        check_eq("abort_state_hold", 32'(cnt), 32'd3);
        cmd0 = 1'b1; cmd1 = 1'b1; req = 2'b11;
        @(negedge clk);
        check_eq("abort_next_gnt", 32'(gnt), 32'b10);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);

        run_load(0);                 // priority now 1, state 0

        // Reset in the middle of a burst by requester 1
        cmd1 = 1'b0; len1 = 3'd5; req = 2'b10;
        @(negedge clk);
        check_eq("mid_inc", 32'(inc), 32'd1);
        @(negedge clk);
        check_eq("mid_state", 32'(cnt), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
        check_eq("mid_rst_ctl", 32'({done, load, inc, busy, wrap}), 32'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_state", 32'(cnt), 32'd1);
        reset_n = 1'b1;
        cmd0 = 1'b1; cmd1 = 1'b1; req = 2'b11;
        @(negedge clk);
        check_eq("post_rst_ptr", 32'(gnt), 32'b01);
        req = 2'b00;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        n_errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
